// File: rtl/priority_scan_pkg.sv
// -----------------------------------------------------------------------------
// priority_scan_pkg
// Shared types and helpers for priority_scan_encoder and its priority_pick
// sub-module:
//   state_t     - scan FSM state (IDLE, SCAN)
//   MAX_INPUTS  - upper bound on the request width accepted by popcount()
//   calc_idx_w  - index width for a given number of request inputs
//   popcount    - number of set bits; used only when PRIORITY_SCAN_COUNT_EN
//                 is defined
// -----------------------------------------------------------------------------
package priority_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int MAX_INPUTS = 256;

   // A request vector of 2 or more inputs needs at least one index bit.
   function automatic int calc_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Callers zero-extend their vector to MAX_INPUTS bits.
   function automatic int popcount(input logic [MAX_INPUTS-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < MAX_INPUTS; i++) begin
         c += int'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/priority_scan_encoder_pick.sv
// -----------------------------------------------------------------------------
// priority_pick
// Combinational priority selector over a request vector.
//   i_vec  - request vector, bit i = source i
//   o_idx  - index of the winning set bit (highest when HIGH_FIRST != 0,
//            lowest otherwise); 0 when no bit is set
//   o_any  - at least one bit is set
//   o_one  - exactly one bit is set
// -----------------------------------------------------------------------------
module priority_pick
   import priority_scan_pkg::*;
#(
   parameter  int NUM_INPUTS = 8,
   parameter  int HIGH_FIRST = 1,
   localparam int IDX_W      = calc_idx_w(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] i_vec,
   output logic [IDX_W-1:0]      o_idx,
   output logic                  o_any,
   output logic                  o_one
);

   // The loop runs toward the winner so the last match seen is the one kept.
   always_comb begin
      o_idx = '0;
      if (HIGH_FIRST != 0) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
         end
      end else begin
         for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
         end
      end
   end

   assign o_any = |i_vec;
   // v & (v-1) clears the lowest set bit; nothing left means a single bit.
   assign o_one = o_any && ((i_vec & (i_vec - NUM_INPUTS'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// -----------------------------------------------------------------------------
// priority_scan_encoder
// Captures a request vector in one load, then emits the index of every set
// bit, one per valid/ready handshake, in priority order (HIGH_FIRST).
// Optional feature macro: PRIORITY_SCAN_COUNT_EN adds Remaining_Count_Out.
// Ports:
//   Clock_In            - clock, rising edge
//   Reset_In            - asynchronous active-low reset
//   Load_In / Data_In   - capture request vector while not busy
//   Flush_In            - synchronous abort of the current scan
//   Ready_In            - consumer accepts Index_Out
//   Valid_Out           - Index_Out is valid
//   Index_Out           - current highest-priority pending index (0 if !valid)
//   Last_Out            - Index_Out is the final pending index
//   Busy_Out            - scan in progress, loads ignored
//   Zero_Out            - one-cycle pulse after an all-zero load
//   Remaining_Count_Out - pending bit count (PRIORITY_SCAN_COUNT_EN only)
// -----------------------------------------------------------------------------
module priority_scan_encoder
   import priority_scan_pkg::*;
#(
   parameter  int NUM_INPUTS = 8,
   parameter  int HIGH_FIRST = 1,
   localparam int IDX_W      = calc_idx_w(NUM_INPUTS)
`ifdef PRIORITY_SCAN_COUNT_EN
   ,
   localparam int CNT_W      = $clog2(NUM_INPUTS + 1)
`endif
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   input  logic                  Load_In,
   input  logic [NUM_INPUTS-1:0] Data_In,
   input  logic                  Flush_In,
   input  logic                  Ready_In,
   output logic                  Valid_Out,
   output logic [IDX_W-1:0]      Index_Out,
   output logic                  Last_Out,
   output logic                  Busy_Out,
   output logic                  Zero_Out
`ifdef PRIORITY_SCAN_COUNT_EN
   ,
   output logic [CNT_W-1:0]      Remaining_Count_Out
`endif
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_INPUTS-1:0] r_pending;
   logic [NUM_INPUTS-1:0] w_pending_nxt;
   logic                  r_zero;
   logic                  w_zero_nxt;

   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_pick_any;
   logic                  w_pick_one;
   logic                  w_valid;
   logic [NUM_INPUTS-1:0] w_clear_mask;

   priority_pick #(
      .NUM_INPUTS (NUM_INPUTS),
      .HIGH_FIRST (HIGH_FIRST)
   ) u_pick (
      .i_vec (r_pending),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any),
      .o_one (w_pick_one)
   );

   assign w_clear_mask = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << w_pick_idx;

   // State, pending vector and zero pulse register
   always_ff @(posedge Clock_In or negedge Reset_In) begin
      if (!Reset_In) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_zero    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_zero    <= w_zero_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_zero_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            // A flush in IDLE does nothing itself but suppresses a load.
            if (Load_In && !Flush_In) begin
               if (Data_In != '0) begin
                  w_pending_nxt = Data_In;
                  w_state_nxt   = SCAN;
               end else begin
                  w_zero_nxt    = 1'b1;
               end
            end
         end
         SCAN: begin
            // Flush wins over a simultaneous handshake.
            if (Flush_In) begin
               w_pending_nxt = '0;
               w_state_nxt   = IDLE;
            end else if (w_valid && Ready_In) begin
               w_pending_nxt = r_pending & ~w_clear_mask;
               if (w_pick_one) w_state_nxt = IDLE;
            end
         end
         default: begin
            w_pending_nxt = '0;
            w_state_nxt   = IDLE;
         end
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      w_valid   = (r_state == SCAN) && w_pick_any;
      Valid_Out = w_valid;
      Busy_Out  = (r_state == SCAN);
      Index_Out = w_valid ? w_pick_idx : '0;
      Last_Out  = w_valid && w_pick_one;
      Zero_Out  = r_zero;
   end

`ifdef PRIORITY_SCAN_COUNT_EN
   assign Remaining_Count_Out = (r_state == SCAN)
                              ? CNT_W'(popcount(MAX_INPUTS'(r_pending)))
                              : '0;
`endif

endmodule
